// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions for the MEM stage: WB control bit positions,
// datapath widths and a small address helper.
package mem_stage_pkg;

    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef logic [1:0]        wbCtl_t;
    typedef logic [DATA_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regIdx_t;

    function automatic logic isMisaligned(input logic [1:0] byteOffset);
        return |byteOffset;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM-side bundle into the MEM stage plus the MEM/WB and hazard outputs.
// The master side is the upstream pipeline; the slave side is mem_stage.
interface mem_stage_if;
    import mem_stage_pkg::*;

    wbCtl_t  wb_ctlout;
    logic    branch;
    logic    memread;
    logic    memwrite;
    word_t   EX_MEM_NPC;
    logic    zero;
    word_t   alu_result;
    word_t   rdata2out;
    regIdx_t five_bit_muxout;

    logic    PCSrc;
    word_t   branch_target;
    logic    mem_stall;
    logic    misalign;
    wbCtl_t  mem_wb_ctl;
    word_t   read_data;
    word_t   mem_alu_result;
    regIdx_t mem_write_reg;

    modport master (
        output wb_ctlout, branch, memread, memwrite, EX_MEM_NPC, zero,
               alu_result, rdata2out, five_bit_muxout,
        input  PCSrc, branch_target, mem_stall, misalign, mem_wb_ctl,
               read_data, mem_alu_result, mem_write_reg
    );

    modport slave (
        input  wb_ctlout, branch, memread, memwrite, EX_MEM_NPC, zero,
               alu_result, rdata2out, five_bit_muxout,
        output PCSrc, branch_target, mem_stall, misalign, mem_wb_ctl,
               read_data, mem_alu_result, mem_write_reg
    );

endinterface

// File: rtl/mem_stage_data_mem.sv
// Word-addressed data memory: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module data_mem #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: data-memory access with configurable wait latency,
// branch resolution and the MEM/WB pipeline latch.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int MEM_LAT = 0
) (
    input  logic         clk,
    input  logic         rst,
    mem_stage_if.slave   bus
);

    localparam int CNT_W = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
    localparam logic [CNT_W-1:0] LAT_V = CNT_W'(MEM_LAT);

    logic [CNT_W-1:0]  r_cnt;
    wbCtl_t            r_memWbCtl;
    word_t             r_readData;
    word_t             r_memAluResult;
    regIdx_t           r_memWriteReg;
    logic              r_misalign;

    logic              w_access;
    logic              w_stall;
    logic              w_complete;
    logic              w_memWe;
    logic [ADDR_W-1:0] w_wordIdx;
    word_t             w_memRdata;

    assign w_access   = bus.memread | bus.memwrite;
    assign w_stall    = w_access & (r_cnt != LAT_V);
    assign w_complete = w_access & ~w_stall;
    assign w_wordIdx  = bus.alu_result[ADDR_W+1:2];

    // Gating with rst drops a store whose completing edge coincides with reset.
    assign w_memWe = w_complete & bus.memwrite & ~rst;

    data_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .i_clk   (clk),
        .i_we    (w_memWe),
        .i_addr  (w_wordIdx),
        .i_wdata (bus.rdata2out),
        .o_rdata (w_memRdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt          <= '0;
            r_memWbCtl     <= '0;
            r_readData     <= '0;
            r_memAluResult <= '0;
            r_memWriteReg  <= '0;
            r_misalign     <= 1'b0;
        end else begin
            r_misalign <= w_complete & isMisaligned(bus.alu_result[1:0]);
            if (w_stall) begin
                r_cnt      <= r_cnt + CNT_W'(1);
                r_memWbCtl <= '0;
            end else begin
                r_cnt          <= '0;
                r_memWbCtl     <= bus.wb_ctlout;
                r_memAluResult <= bus.alu_result;
                r_memWriteReg  <= bus.five_bit_muxout;
                r_readData     <= (bus.memread & ~bus.memwrite) ? w_memRdata : '0;
            end
        end
    end

    assign bus.PCSrc          = bus.branch & bus.zero;
    assign bus.branch_target  = bus.EX_MEM_NPC;
    assign bus.mem_stall      = w_stall;
    assign bus.misalign       = r_misalign;
    assign bus.mem_wb_ctl     = r_memWbCtl;
    assign bus.read_data      = r_readData;
    assign bus.mem_alu_result = r_memAluResult;
    assign bus.mem_write_reg  = r_memWriteReg;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: one instance with single-cycle memory and
// one with a two-cycle wait, driven with hand-computed vectors.
module tb_mem_stage;

    logic clk;
    logic rst0;
    logic rst2;

    int checkCount;
    int failCount;

    mem_stage_if bus0 ();
    mem_stage_if bus2 ();

    mem_stage #(.ADDR_W(8), .MEM_LAT(0)) dut0 (
        .clk (clk),
        .rst (rst0),
        .bus (bus0)
    );

    mem_stage #(.ADDR_W(8), .MEM_LAT(2)) dut2 (
        .clk (clk),
        .rst (rst2),
        .bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int which, input logic [1:0] wb, input logic br,
                                 input logic rd, input logic wr, input logic [31:0] npc,
                                 input logic z, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [4:0] dst);
        if (which == 0) begin
            bus0.wb_ctlout = wb;  bus0.branch = br;      bus0.memread = rd;
            bus0.memwrite = wr;   bus0.EX_MEM_NPC = npc; bus0.zero = z;
            bus0.alu_result = addr; bus0.rdata2out = wdata; bus0.five_bit_muxout = dst;
        end else begin
            bus2.wb_ctlout = wb;  bus2.branch = br;      bus2.memread = rd;
            bus2.memwrite = wr;   bus2.EX_MEM_NPC = npc; bus2.zero = z;
            bus2.alu_result = addr; bus2.rdata2out = wdata; bus2.five_bit_muxout = dst;
        end
        #1;
    endtask

    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        rst0 = 1'b1;
        rst2 = 1'b1;
        applyStimulus(0, 2'b00, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 5'd0);
        applyStimulus(2, 2'b00, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 5'd0);
        stepClk();
        stepClk();
        checkOutput("rst_wbctl", 32'(bus0.mem_wb_ctl), 32'h0);
        checkOutput("rst_rdata", bus0.read_data, 32'h0);
        checkOutput("rst_alu", bus0.mem_alu_result, 32'h0);
        checkOutput("rst_wreg", 32'(bus0.mem_write_reg), 32'h0);
        checkOutput("rst_misalign", 32'(bus0.misalign), 32'h0);
        rst0 = 1'b0;
        rst2 = 1'b0;

        // Single-cycle store then load of the same word.
        applyStimulus(0, 2'b00, 0, 0, 1, 32'h0, 0, 32'h10, 32'hDEADBEEF, 5'd0);
        checkOutput("t1_sw_stall", 32'(bus0.mem_stall), 32'h0);
        stepClk();
        checkOutput("t1_sw_rdata", bus0.read_data, 32'h0);
        applyStimulus(0, 2'b11, 0, 1, 0, 32'h0, 0, 32'h10, 32'h0, 5'd8);
        checkOutput("t1_lw_stall", 32'(bus0.mem_stall), 32'h0);
        stepClk();
        checkOutput("t1_lw_rdata", bus0.read_data, 32'hDEADBEEF);
        checkOutput("t1_lw_wbctl", 32'(bus0.mem_wb_ctl), 32'h3);
        checkOutput("t1_lw_alu", bus0.mem_alu_result, 32'h10);
        checkOutput("t1_lw_wreg", 32'(bus0.mem_write_reg), 32'd8);
        checkOutput("t1_lw_misalign", 32'(bus0.misalign), 32'h0);

        // Branch resolution is purely combinational.
        applyStimulus(0, 2'b00, 1, 0, 0, 32'h40, 1, 32'h0, 32'h0, 5'd0);
        checkOutput("t4_pcsrc_taken", 32'(bus0.PCSrc), 32'h1);
        checkOutput("t4_target", bus0.branch_target, 32'h40);
        applyStimulus(0, 2'b00, 1, 0, 0, 32'h40, 0, 32'h0, 32'h0, 5'd0);
        checkOutput("t4_pcsrc_not_taken", 32'(bus0.PCSrc), 32'h0);
        applyStimulus(0, 2'b00, 0, 0, 0, 32'h40, 1, 32'h0, 32'h0, 5'd0);
        checkOutput("t4_pcsrc_no_branch", 32'(bus0.PCSrc), 32'h0);
        stepClk();

        // Simultaneous read and write: store happens, load data is zero.
        applyStimulus(0, 2'b10, 0, 1, 1, 32'h0, 0, 32'h0, 32'h7, 5'd2);
        stepClk();
        checkOutput("t6_rw_rdata", bus0.read_data, 32'h0);
        checkOutput("t6_mem0", dut0.u_mem.r_mem[0], 32'h7);

        // 0x402 wraps to word 0 and is misaligned.
        applyStimulus(0, 2'b11, 0, 1, 0, 32'h0, 0, 32'h402, 32'h0, 5'd4);
        stepClk();
        checkOutput("t5_wrap_rdata", bus0.read_data, 32'h7);
        checkOutput("t5_misalign", 32'(bus0.misalign), 32'h1);
        applyStimulus(0, 2'b00, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 5'd0);
        rst0 = 1'b1;
        stepClk();
        rst0 = 1'b0;
        checkOutput("t6_rst_rdata", bus0.read_data, 32'h0);
        checkOutput("t6_rst_alu", bus0.mem_alu_result, 32'h0);
        checkOutput("t6_rst_wreg", 32'(bus0.mem_write_reg), 32'h0);
        checkOutput("t6_rst_misalign", 32'(bus0.misalign), 32'h0);
        checkOutput("t6_rst_wbctl", 32'(bus0.mem_wb_ctl), 32'h0);

        // Two-wait memory: preload words 8 and 9.
        applyStimulus(2, 2'b00, 0, 0, 1, 32'h0, 0, 32'h20, 32'h1234, 5'd0);
        for (int i = 0; i < 3; i++) stepClk();
        applyStimulus(2, 2'b00, 0, 0, 1, 32'h0, 0, 32'h24, 32'h11, 5'd0);
        for (int i = 0; i < 3; i++) stepClk();

        // Store held three cycles commits exactly once, on the last edge.
        applyStimulus(2, 2'b00, 0, 0, 1, 32'h0, 0, 32'h24, 32'h5, 5'd0);
        checkOutput("t3_stall_c0", 32'(bus2.mem_stall), 32'h1);
        stepClk();
        checkOutput("t3_mem9_c1", dut2.u_mem.r_mem[9], 32'h11);
        checkOutput("t3_stall_c1", 32'(bus2.mem_stall), 32'h1);
        stepClk();
        checkOutput("t3_mem9_c2", dut2.u_mem.r_mem[9], 32'h11);
        checkOutput("t3_stall_c2", 32'(bus2.mem_stall), 32'h0);
        stepClk();
        checkOutput("t3_mem9_done", dut2.u_mem.r_mem[9], 32'h5);

        // Give MEM/WB a non-zero ctl so the load's bubbles are visible.
        applyStimulus(2, 2'b10, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 5'd1);
        stepClk();
        checkOutput("t2_pre_wbctl", 32'(bus2.mem_wb_ctl), 32'h2);
        applyStimulus(2, 2'b11, 0, 1, 0, 32'h0, 0, 32'h20, 32'h0, 5'd3);
        checkOutput("t2_stall_c0", 32'(bus2.mem_stall), 32'h1);
        stepClk();
        checkOutput("t2_bubble_c1", 32'(bus2.mem_wb_ctl), 32'h0);
        checkOutput("t2_stall_c1", 32'(bus2.mem_stall), 32'h1);
        stepClk();
        checkOutput("t2_bubble_c2", 32'(bus2.mem_wb_ctl), 32'h0);
        checkOutput("t2_stall_c2", 32'(bus2.mem_stall), 32'h0);
        stepClk();
        checkOutput("t2_rdata", bus2.read_data, 32'h1234);
        checkOutput("t2_wbctl", 32'(bus2.mem_wb_ctl), 32'h3);
        checkOutput("t2_wreg", 32'(bus2.mem_write_reg), 32'd3);

        // Reset on the would-be completing edge drops the store.
        applyStimulus(2, 2'b10, 0, 0, 1, 32'h0, 0, 32'h24, 32'h99, 5'd6);
        stepClk();
        stepClk();
        rst2 = 1'b1;
        stepClk();
        rst2 = 1'b0;
        applyStimulus(2, 2'b00, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 5'd0);
        checkOutput("t3_rst_mem9", dut2.u_mem.r_mem[9], 32'h5);
        checkOutput("t3_rst_alu", bus2.mem_alu_result, 32'h0);
        checkOutput("t3_rst_rdata", bus2.read_data, 32'h0);
        checkOutput("t3_rst_idle_stall", 32'(bus2.mem_stall), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
